// File: rtl/modport_counter_pkg.sv
// Shared types and constants for the MOD-14 loadable up/down counter.
package counter_pkg;

    localparam int WIDTH   = 4;
    localparam int MODULUS = 14;
    localparam int MAX_CNT = MODULUS - 1;

    typedef logic [WIDTH-1:0] cnt_t;

    // Map any out-of-range value (14, 15) onto 0; legal values pass through.
    function automatic cnt_t legalise(cnt_t v);
        return (v > cnt_t'(MAX_CNT)) ? '0 : v;
    endfunction

endpackage : counter_pkg

// File: rtl/modport_counter_if.sv
// Load/count control and count readback grouped as one bus.
// master: the block driving load/mode/data_in and watching the count.
// slave:  the counter itself.
interface counter_if;
    import counter_pkg::*;

    cnt_t data_in;
    logic load;
    logic mode;
    cnt_t data_out;

    modport master (
        output data_in,
        output load,
        output mode,
        input  data_out
    );

    modport slave (
        input  data_in,
        input  load,
        input  mode,
        output data_out
    );

endinterface : counter_if

// File: rtl/modport_counter_mod14_next_state.sv
// Combinational next-count logic: load priority, up/down steps with
// explicit wrap compares, and recovery from illegal register contents.
module mod14_next_state
    import counter_pkg::*;
(
    input  cnt_t cur,
    input  cnt_t data_in,
    input  logic load,
    input  logic mode,
    output cnt_t nxt
);

    // Pick the next count from the current count and the control inputs.
    always_comb begin
        // NOTE: default assignment first so no path leaves nxt unassigned (no latch);
        // it also makes an X on load/mode fall through to "hold".
        nxt = cur;
        case ({load, mode})
            2'b10, 2'b11: nxt = legalise(data_in);
            2'b01: begin
                // Up: 13 wraps to 0; an illegal 14/15 is also pulled back to 0.
                if (cur >= cnt_t'(MAX_CNT)) nxt = '0;
                else                        nxt = cur + cnt_t'(1);
            end
            2'b00: begin
                // Down: 0 wraps to 13; an illegal 14/15 is pulled back to 0.
                if (cur == '0)                    nxt = cnt_t'(MAX_CNT);
                else if (cur > cnt_t'(MAX_CNT))   nxt = '0;
                else                              nxt = cur - cnt_t'(1);
            end
            default: nxt = cur;
        endcase
    end

endmodule : mod14_next_state

// File: rtl/modport_counter.sv
// Loadable MOD-14 up/down counter. Loads or counts on every rising edge
// while out of reset; the count is held in a single register.
module modport_counter
    import counter_pkg::*;
(
    input  logic     clock,
    input  logic     rest,
    counter_if.slave bus
);

    cnt_t cnt_q;
    cnt_t cnt_d;

    mod14_next_state u_next (
        .cur     (cnt_q),
        .data_in (bus.data_in),
        .load    (bus.load),
        .mode    (bus.mode),
        .nxt     (cnt_d)
    );

    // Count register: asynchronous clear, otherwise take the next count.
    always_ff @(posedge clock or negedge rest) begin
        // NOTE: non-blocking assignment for state so every register samples
        // pre-edge values regardless of block ordering.
        if (!rest) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign bus.data_out = cnt_q;

endmodule : modport_counter

// File: tb/tb_modport_counter.sv
// Directed table vectors, hand-written reset sequence, and a random run
// against a small reference model for the MOD-14 counter.
module tb_modport_counter;
    import counter_pkg::*;

    logic clock = 1'b0;
    logic rest;

    counter_if bus ();

    modport_counter dut (
        .clock (clock),
        .rest  (rest),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input cnt_t act, input cnt_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        string name;
        logic  load;
        logic  mode;
        cnt_t  data_in;
        cnt_t  exp;
    } vec_t;

    vec_t vecs[19];

    // Watchdog so the run always ends even if the clock stalls.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int exp_m;
        logic r_load, r_mode, r_rest;
        cnt_t r_data;

        vecs[0]  = '{"up_load11",   1'b1, 1'b0, 4'd11, 4'd11};
        vecs[1]  = '{"up_12",       1'b0, 1'b1, 4'd3,  4'd12};
        vecs[2]  = '{"up_13",       1'b0, 1'b1, 4'd3,  4'd13};
        vecs[3]  = '{"up_wrap0",    1'b0, 1'b1, 4'd3,  4'd0};
        vecs[4]  = '{"up_1",        1'b0, 1'b1, 4'd3,  4'd1};
        vecs[5]  = '{"dn_load2",    1'b1, 1'b1, 4'd2,  4'd2};
        vecs[6]  = '{"dn_1",        1'b0, 1'b0, 4'd9,  4'd1};
        vecs[7]  = '{"dn_0",        1'b0, 1'b0, 4'd9,  4'd0};
        vecs[8]  = '{"dn_wrap13",   1'b0, 1'b0, 4'd9,  4'd13};
        vecs[9]  = '{"dn_12",       1'b0, 1'b0, 4'd9,  4'd12};
        vecs[10] = '{"prio_load5",  1'b1, 1'b1, 4'd5,  4'd5};
        vecs[11] = '{"prio_next6",  1'b0, 1'b1, 4'd5,  4'd6};
        vecs[12] = '{"illegal15",   1'b1, 1'b1, 4'd15, 4'd0};
        vecs[13] = '{"illegal14",   1'b1, 1'b0, 4'd14, 4'd0};
        vecs[14] = '{"load13",      1'b1, 1'b0, 4'd13, 4'd13};
        vecs[15] = '{"up13_to0",    1'b0, 1'b1, 4'd1,  4'd0};
        vecs[16] = '{"load0",       1'b1, 1'b1, 4'd0,  4'd0};
        vecs[17] = '{"dn0_to13",    1'b0, 1'b0, 4'd1,  4'd13};
        vecs[18] = '{"load7",       1'b1, 1'b0, 4'd7,  4'd7};

        // Reset state.
        rest        = 1'b0;
        bus.load    = 1'b0;
        bus.mode    = 1'b1;
        bus.data_in = '0;
        #1;
        check("reset_state", bus.data_out, 4'd0);
        @(posedge clock); #1;
        check("reset_held", bus.data_out, 4'd0);
        rest = 1'b1;

        // Directed table.
        for (int i = 0; i < 19; i++) begin
            bus.load    = vecs[i].load;
            bus.mode    = vecs[i].mode;
            bus.data_in = vecs[i].data_in;
            @(posedge clock); #1;
            check(vecs[i].name, bus.data_out, vecs[i].exp);
        end

        // Asynchronous reset mid-cycle with count at 7 and a load pending.
        #3;
        bus.load    = 1'b1;
        bus.data_in = 4'd9;
        rest        = 1'b0;
        #1;
        check("rst_async", bus.data_out, 4'd0);
        @(posedge clock); #1;
        check("rst_hold1", bus.data_out, 4'd0);
        @(posedge clock); #1;
        check("rst_hold2", bus.data_out, 4'd0);
        rest     = 1'b1;
        bus.load = 1'b0;
        bus.mode = 1'b1;
        @(posedge clock); #1;
        check("rst_release_up", bus.data_out, 4'd1);

        // Random run against a reference model.
        exp_m = 1;
        for (int c = 0; c < 1000; c++) begin
            r_load = ($urandom_range(0, 3) == 0);
            r_mode = 1'($urandom_range(0, 1));
            r_data = cnt_t'($urandom_range(0, 15));
            r_rest = ($urandom_range(0, 31) != 0);
            bus.load    = r_load;
            bus.mode    = r_mode;
            bus.data_in = r_data;
            rest        = r_rest;
            if (!r_rest)     exp_m = 0;
            else if (r_load) exp_m = (int'(r_data) > 13) ? 0 : int'(r_data);
            else if (r_mode) exp_m = (exp_m + 1) % 14;
            else             exp_m = (exp_m == 0) ? 13 : exp_m - 1;
            @(posedge clock); #1;
            check("rand_model", bus.data_out, cnt_t'(exp_m));
            total++;
            if (!(bus.data_out <= 4'd13)) begin
                bad++;
                $display("FAIL rand_range: got %0d expected <= 13", bus.data_out);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_modport_counter
